// File: rtl/misao_pkg.sv
// ----------------------------------------------------------------------------
// misao_pkg
// Shared types and constants for the misao external-memory arbiter.
//   arb_state_t  : arbiter FSM states (IDLE, BEAT0, BEAT1)
//   PORT_CORE    : port index of the misao core (fetch + XMEM)
//   PORT_AUX     : port index of the aux master (loader / debug DMA)
//   beat_byte()  : selects the byte of a 16-bit word carried by a given beat
// ----------------------------------------------------------------------------
package misao_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT0 = 2'd1,
        BEAT1 = 2'd2
    } arb_state_t;

    localparam logic PORT_CORE = 1'b0;
    localparam logic PORT_AUX  = 1'b1;

    // Little-endian split: the first beat carries [7:0], the second [15:8].
    function automatic logic [7:0] beat_byte(input logic [15:0] word, input logic high);
        return high ? word[15:8] : word[7:0];
    endfunction

endpackage

// File: rtl/misao_rr_arb.sv
// ----------------------------------------------------------------------------
// misao_rr_arb
// Two-way request picker with optional round-robin fairness.
//   clk    in   clock, rising edge
//   rst    in   asynchronous, active-high reset
//   req    in   [1:0] request vector, bit n = port n
//   rr_en  in   1 = round-robin on contention, 0 = port 0 always wins
//   update in   a grant was taken this cycle; remember who got it
//   gnt    out  [1:0] one-hot (or zero) grant, combinational from req
// ----------------------------------------------------------------------------
module misao_rr_arb
    import misao_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       rr_en,
    input  logic       update,
    output logic [1:0] gnt
);

    // Port that received the most recent grant. Starting at PORT_AUX makes
    // the first contended grant after reset go to the core.
    logic last;

    // NOTE: every output of a combinational block gets a default first so no
    // path through the if/else chain can leave it unassigned and infer a latch.
    always_comb begin
        gnt = 2'b00;
        if (req == 2'b11) begin
            gnt = (rr_en && (last == PORT_CORE)) ? 2'b10 : 2'b01;
        end else if (req[0]) begin
            gnt = 2'b01;
        end else if (req[1]) begin
            gnt = 2'b10;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last <= PORT_AUX;
        end else if (update) begin
            last <= gnt[1];
        end
    end

endmodule

// File: rtl/misao_mem_arbiter.sv
// ----------------------------------------------------------------------------
// misao_mem_arbiter
// Shares the single 8-bit external memory port between the misao core
// (port 0) and the aux master (port 1). 16-bit transfers are split into two
// little-endian byte beats: low byte at addr, high byte at addr+1.
//
//   clk, rst                 clock (rising edge), async active-high reset
//   req/we/wide/addr/wdata   per-port command, held until gnt
//   gnt0/gnt1                1-cycle pulse, command accepted at this edge
//   done0/done1              1-cycle pulse, transaction complete
//   rdata0/rdata1            read data, held until that port's next read
//   mem_enable_read          read strobe, mem_data_in valid same cycle
//   mem_enable_write         write strobe, memory writes at rising edge
//   mem_addr                 beat address
//   mem_rw                   1 = write beat
//   mem_data_out             write byte
//   mem_data_in              read byte
// ----------------------------------------------------------------------------
module misao_mem_arbiter
    import misao_pkg::*;
#(
    parameter int ADDR_W = 15,
    parameter bit RR_EN  = 1'b1
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic              wide0,
    input  logic              wide1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [15:0]       wdata0,
    input  logic [15:0]       wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              done0,
    output logic              done1,
    output logic [15:0]       rdata0,
    output logic [15:0]       rdata1,
    output logic              mem_enable_read,
    output logic              mem_enable_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rw,
    output logic [7:0]        mem_data_out,
    input  logic [7:0]        mem_data_in
);

    arb_state_t        state;

    // Command latched from the winning port at the grant edge.
    logic              cmd_port;
    logic              cmd_we;
    logic              cmd_wide;
    logic [ADDR_W-1:0] cmd_addr;
    logic [15:0]       cmd_wdata;

    logic [1:0]        arb_gnt;
    logic              take;
    logic              in_beat;
    logic              last_beat;
    logic [ADDR_W-1:0] beat_addr;

    misao_rr_arb u_rr_arb (
        .clk    (clk),
        .rst    (rst),
        .req    ({req1, req0}),
        .rr_en  (RR_EN),
        .update (take),
        .gnt    (arb_gnt)
    );

    // Grants only exist in IDLE; masking with rst keeps them low while the
    // design is held in reset even though IDLE is the reset state.
    assign gnt0 = !rst && (state == IDLE) && arb_gnt[0];
    assign gnt1 = !rst && (state == IDLE) && arb_gnt[1];
    assign take = gnt0 || gnt1;

    assign in_beat   = (state == BEAT0) || (state == BEAT1);
    assign last_beat = ((state == BEAT0) && !cmd_wide) || (state == BEAT1);

    // Second beat address wraps naturally at 2^ADDR_W.
    assign beat_addr = (state == BEAT1) ? cmd_addr + ADDR_W'(1) : cmd_addr;

    // Memory pins decode straight from the state register, so an async reset
    // drops the strobes in the same cycle it is asserted.
    always_comb begin
        mem_enable_read  = 1'b0;
        mem_enable_write = 1'b0;
        mem_rw           = 1'b0;
        mem_addr         = '0;
        mem_data_out     = 8'h00;
        if (in_beat) begin
            mem_enable_read  = !cmd_we;
            mem_enable_write = cmd_we;
            mem_rw           = cmd_we;
            mem_addr         = beat_addr;
            if (cmd_we) begin
                mem_data_out = beat_byte(cmd_wdata, state == BEAT1);
            end
        end
    end

    // FSM and command latch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cmd_port  <= PORT_CORE;
            cmd_we    <= 1'b0;
            cmd_wide  <= 1'b0;
            cmd_addr  <= '0;
            cmd_wdata <= 16'h0000;
        end else begin
            case (state)
                IDLE: begin
                    if (take) begin
                        state     <= BEAT0;
                        cmd_port  <= gnt1 ? PORT_AUX : PORT_CORE;
                        cmd_we    <= gnt1 ? we1    : we0;
                        cmd_wide  <= gnt1 ? wide1  : wide0;
                        cmd_addr  <= gnt1 ? addr1  : addr0;
                        cmd_wdata <= gnt1 ? wdata1 : wdata0;
                    end
                end
                BEAT0:   state <= cmd_wide ? BEAT1 : IDLE;
                BEAT1:   state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Read capture. A narrow read clears [15:8]; a wide read fills it on the
    // second beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata0 <= 16'h0000;
            rdata1 <= 16'h0000;
        end else if (in_beat && !cmd_we) begin
            if (state == BEAT0) begin
                if (cmd_port == PORT_AUX) rdata1 <= {8'h00, mem_data_in};
                else                      rdata0 <= {8'h00, mem_data_in};
            end else begin
                if (cmd_port == PORT_AUX) rdata1[15:8] <= mem_data_in;
                else                      rdata0[15:8] <= mem_data_in;
            end
        end
    end

    // Completion pulse lands in the cycle after the final beat, which is
    // also the IDLE cycle where the next grant may already be issued.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done0 <= 1'b0;
            done1 <= 1'b0;
        end else begin
            done0 <= last_beat && (cmd_port == PORT_CORE);
            done1 <= last_beat && (cmd_port == PORT_AUX);
        end
    end

endmodule
